// File: rtl/nibble_sub_pkg.sv
`default_nettype none
// ============================================================================
// nibble_sub_pkg : shared FSM states, nibble width and nibble-count helper
// Revision: 1.0
// ============================================================================
package nibble_sub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  function automatic int calc_nib(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_sub4.sv
`default_nettype none
// ============================================================================
// nibble_sub4 : combinational 4-bit borrow-ripple subtract slice
// Revision: 1.0
// ============================================================================
module nibble_sub4
  import nibble_sub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                bi,
  output logic [NIBBLE_W-1:0] d,
  output logic                bo
);

  logic [NIBBLE_W:0] w_borrow;

  assign w_borrow[0] = bi;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign d[i]          = a[i] ^ b[i] ^ w_borrow[i];
    assign w_borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_borrow[i]);
  end

  assign bo = w_borrow[NIBBLE_W];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// nibble_serial_subtractor : D = A - B - Bin, one nibble per cycle, valid/ready
// Optional Z/V flag ports with macro SUB_FLAGS_EN.   Revision: 1.0
// ============================================================================
module nibble_serial_subtractor
  import nibble_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SUB_FLAGS_EN
  ,
  output logic             Z,
  output logic             V
`endif
);

  localparam int c_nib   = calc_nib(WIDTH);
  localparam int c_cnt_w = $clog2(c_nib + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_nib - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 4");
  end

  sub_state_t          r_state, w_next;
  logic [WIDTH-1:0]    r_a, r_b, r_d, w_d_shift;
  logic                r_borrow;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [NIBBLE_W-1:0] w_slice_d;
  logic                w_slice_bo;

  nibble_sub4 u_slice (
    .a  (r_a[NIBBLE_W-1:0]),
    .b  (r_b[NIBBLE_W-1:0]),
    .bi (r_borrow),
    .d  (w_slice_d),
    .bo (w_slice_bo)
  );

  // New nibble enters at the top so nibble 0 lands at the LSB after c_nib shifts.
  if (c_nib == 1) begin : g_d_single
    assign w_d_shift = w_slice_d;
  end else begin : g_d_multi
    assign w_d_shift = {w_slice_d, r_d[WIDTH-1:NIBBLE_W]};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)        w_next = BUSY;
      BUSY:    if (r_cnt == c_last) w_next = DONE;
      DONE:    if (out_ready)       w_next = IDLE;
      default:                      w_next = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign D         = r_d;
  assign Bout      = r_borrow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a      <= A;
          r_b      <= B;
          r_borrow <= Bin;
          r_cnt    <= '0;
        end
        BUSY: begin
          r_a      <= r_a >> NIBBLE_W;
          r_b      <= r_b >> NIBBLE_W;
          r_d      <= w_d_shift;
          r_borrow <= w_slice_bo;
          r_cnt    <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SUB_FLAGS_EN
  logic r_a_msb, r_b_msb, r_z, r_v;

  // Operand MSBs are shifted away during BUSY, so keep them from accept time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_z     <= 1'b0;
      r_v     <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_a_msb <= A[WIDTH-1];
      r_b_msb <= B[WIDTH-1];
    end else if (r_state == BUSY && r_cnt == c_last) begin
      r_z <= (w_d_shift == '0);
      r_v <= (r_a_msb != r_b_msb) && (w_d_shift[WIDTH-1] != r_a_msb);
    end
  end

  assign Z = r_z;
  assign V = r_v;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// tb_nibble_serial_subtractor : randomized + directed bench with arithmetic model
// Revision: 1.0
// ============================================================================
module tb_nibble_serial_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         in_ready, out_valid, Bout;
  logic [W-1:0] D;
  logic         Z, V;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout)
`ifdef SUB_FLAGS_EN
    ,
    .Z         (Z),
    .V         (V)
`endif
  );

`ifndef SUB_FLAGS_EN
  assign Z = 1'b0;
  assign V = 1'b0;
`endif

  // Reference: plain wide arithmetic; borrow is the sign bit of the extended result.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, b, input logic bin);
    return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  endfunction

  function automatic logic ref_v(input logic [W-1:0] a, b, d);
    return (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
  endfunction

  // Presents one operand set in IDLE, waits (bounded) for out_valid, leaves DUT in DONE.
  task automatic issue(input logic [W-1:0] a, b, input logic bin,
                       output logic [W-1:0] d, output logic bo,
                       output logic z, output logic v, output int lat);
    @(negedge clk);
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d = D; bo = Bout; z = Z; v = V;
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({in_ready, out_valid, D, Bout, Z, V} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_values: got ir=%b ov=%b D=%h Bo=%b Z=%b V=%b, want ir=1 ov=0 D=0 Bo=0 Z=0 V=0",
               in_ready, out_valid, D, Bout, Z, V);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [3] = '{16'h1234, 16'h0000, 16'h1000};
    logic [W-1:0] vb [3] = '{16'h0234, 16'h0001, 16'h0000};
    logic         vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] ed [3] = '{16'h1000, 16'hFFFF, 16'h0FFF};
    logic         eb [3] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] d; logic bo, z, v; int lat;
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], vc[i], d, bo, z, v, lat);
      tests_run++;
      if (lat !== 4) begin
        tests_failed++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, want 4", i, lat);
      end
      tests_run++;
      if ({d, bo} !== {ed[i], eb[i]}) begin
        tests_failed++;
        $display("FAIL directed_result[%0d]: got D=%h Bout=%b, want D=%h Bout=%b",
                 i, d, bo, ed[i], eb[i]);
      end
      release_result();
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL directed_return_idle[%0d]: got ir=%b ov=%b, want ir=1 ov=0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, d; logic bin, bo, z, v; int lat;
    logic [W:0] exp;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      if (i == 0) begin a = '0; b = '1; bin = 1'b1; end
      if (i == 1) begin a = '1; b = '0; bin = 1'b0; end
      exp = ref_sub(a, b, bin);
      issue(a, b, bin, d, bo, z, v, lat);
      tests_run++;
      if (lat !== 4 || {bo, d} !== exp) begin
        tests_failed++;
        $display("FAIL random[%0d] %h-%h-%b: got D=%h Bout=%b lat=%0d, want D=%h Bout=%b lat=4",
                 i, a, b, bin, d, bo, lat, exp[W-1:0], exp[W]);
      end
`ifdef SUB_FLAGS_EN
      tests_run++;
      if (z !== (exp[W-1:0] == '0) || v !== ref_v(a, b, exp[W-1:0])) begin
        tests_failed++;
        $display("FAIL random_flags[%0d]: got Z=%b V=%b, want Z=%b V=%b",
                 i, z, v, (exp[W-1:0] == '0), ref_v(a, b, exp[W-1:0]));
      end
`endif
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d; logic bo, z, v; int lat; int bad;
    logic [W:0] exp;
    exp = ref_sub(16'hBEEF, 16'hCAFE, 1'b1);
    issue(16'hBEEF, 16'hCAFE, 1'b1, d, bo, z, v, lat);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {Bout, D} !== exp) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL backpressure_hold: %0d unstable cycles (last ov=%b ir=%b D=%h Bo=%b), want 0 (D=%h Bo=%b)",
               bad, out_valid, in_ready, D, Bout, exp[W-1:0], exp[W]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {Bout, D} !== exp) begin
      tests_failed++;
      $display("FAIL backpressure_release: got ir=%b ov=%b D=%h Bo=%b, want ir=1 ov=0 D=%h Bo=%b",
               in_ready, out_valid, D, Bout, exp[W-1:0], exp[W]);
    end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] d; logic bo, z, v; int lat; int seen;
    @(negedge clk);
    A = 16'h9ABC; B = 16'h1111; Bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if ({in_ready, out_valid, D, Bout, Z, V} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL abort_reset_values: got ir=%b ov=%b D=%h Bo=%b Z=%b V=%b, want ir=1 ov=0 D=0 Bo=0 Z=0 V=0",
               in_ready, out_valid, D, Bout, Z, V);
    end
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL abort_no_valid: got %0d out_valid cycles, want 0", seen);
    end
    issue(16'h0005, 16'h0003, 1'b0, d, bo, z, v, lat);
    tests_run++;
    if ({d, bo} !== {16'h0002, 1'b0} || lat !== 4) begin
      tests_failed++;
      $display("FAIL abort_next_op: got D=%h Bout=%b lat=%0d, want D=0002 Bout=0 lat=4", d, bo, lat);
    end
    release_result();
  endtask

`ifdef SUB_FLAGS_EN
  task automatic test_flags();
    logic [W-1:0] d; logic bo, z, v; int lat;
    issue(16'h8000, 16'h0001, 1'b0, d, bo, z, v, lat);
    tests_run++;
    if ({d, v, z} !== {16'h7FFF, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL flags_overflow: got D=%h V=%b Z=%b, want D=7fff V=1 Z=0", d, v, z);
    end
    release_result();
    issue(16'h5A5A, 16'h5A5A, 1'b0, d, bo, z, v, lat);
    tests_run++;
    if ({d, z, v, bo} !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL flags_zero: got D=%h Z=%b V=%b Bout=%b, want D=0000 Z=1 V=0 Bout=0", d, z, v, bo);
    end
    release_result();
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
`ifdef SUB_FLAGS_EN
    test_flags();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
